// File: rtl/gray_step_checker.sv
// Decodes a Gray-coded count and checks that successive samples move by -1, 0 or +1.
// 1-cycle latency: a sample accepted at edge N is reflected on bin_out/flags after edge N.
// No backpressure: one sample per cycle, every in_valid sample is consumed.
module gray_step_checker #(
    parameter int WIDTH     = 4,
    parameter int ERR_LIMIT = 3,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             in_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_valid,
    output logic             dir,
    output logic             step_err,
    output logic [CNT_W-1:0] err_count,
    output logic             locked,
    output logic             fault
);

    localparam int CONS_W = (ERR_LIMIT < 1) ? 1 : $clog2(ERR_LIMIT + 1);
    localparam logic [CONS_W-1:0] CONS_MAX = CONS_W'(ERR_LIMIT);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        FAULT   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CONS_W-1:0]  cons_q;
    logic [WIDTH-1:0]   b_new;
    logic [WIDTH-1:0]   d;
    logic               step_up;
    logic               step_dn;
    logic               step_hold;
    logic               classify;
    logic               bad_evt;
    logic               limit_hit;

    // Binary-reflected Gray to binary: each bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Decode the incoming sample and classify its step against the last accepted value.
    // bin_out doubles as the reference: it is loaded with every accepted sample.
    always_comb begin
        b_new     = gray2bin(gray_in);
        d         = b_new - bin_out;
        step_hold = (d == '0);
        step_up   = (d == WIDTH'(1));
        step_dn   = (d == {WIDTH{1'b1}});
        classify  = in_valid && !clear && (state_q != ACQUIRE);
        bad_evt   = classify && !(step_hold || step_up || step_dn);
        limit_hit = bad_evt && ((int'(cons_q) + 1) >= ERR_LIMIT);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACQUIRE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clear always returns to ACQUIRE; FAULT is otherwise sticky.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ACQUIRE;
        end else if (in_valid) begin
            case (state_q)
                ACQUIRE: state_d = TRACK;
                TRACK:   state_d = limit_hit ? FAULT : TRACK;
                FAULT:   state_d = FAULT;
                default: state_d = ACQUIRE;
            endcase
        end
    end

    // State-decoded outputs.
    always_comb begin
        locked = (state_q == TRACK);
        fault  = (state_q == FAULT);
    end

    // Datapath: decoded value, pulses, direction and error counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_out   <= '0;
            out_valid <= 1'b0;
            step_err  <= 1'b0;
            dir       <= 1'b0;
            err_count <= '0;
            cons_q    <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            step_err  <= 1'b0;
            dir       <= 1'b0;
            err_count <= '0;
            cons_q    <= '0;
        end else if (in_valid) begin
            bin_out   <= b_new;
            out_valid <= 1'b1;
            step_err  <= bad_evt;
            if (classify) begin
                if (bad_evt) begin
                    if (err_count != {CNT_W{1'b1}}) begin
                        err_count <= err_count + CNT_W'(1);
                    end
                    if (cons_q != CONS_MAX) begin
                        cons_q <= cons_q + CONS_W'(1);
                    end
                end else begin
                    cons_q <= '0;
                    if (step_up) begin
                        dir <= 1'b1;
                    end else if (step_dn) begin
                        dir <= 1'b0;
                    end
                end
            end
        end else begin
            out_valid <= 1'b0;
            step_err  <= 1'b0;
        end
    end

endmodule
